pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central pipeline control stage, placed directly downstream of the forwarding unit.
- Consumes the forwarding unit's stall request, the decode-stage branch-taken decision, and the instruction- and data-memory ready handshakes.
- Produces per-stage pipeline-register enables, flush/bubble controls and saturating performance counters.
- Every pipeline register and the PC in the core takes its enable/flush from this block.

Parameters:
- CNT_W, 16, width of each saturating performance counter.
- MAX_STALL, 8, consecutive hazard-stall cycles after which the sticky hang flag is set (legal range 1..255).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- i_stall  input  1  hazard stall request from the forwarding unit (load-use or branch dependency).
- i_branch_taken  input  1  branch/jump resolved taken in decode this cycle.
- i_imem_ready  input  1  fetch data valid this cycle.
- i_dmem_ready  input  1  data memory access complete/accepting; low means MEM stage is busy.
- o_pc_en  output  1  PC update enable.
- o_if_id_en  output  1  IF/ID register enable.
- o_if_id_flush  output  1  load NOP into IF/ID.
- o_id_ex_en  output  1  ID/EX register enable.
- o_id_ex_flush  output  1  load bubble into ID/EX.
- o_ex_mem_en  output  1  EX/MEM register enable.
- o_mem_wb_en  output  1  MEM/WB register enable.
- o_state  output  2  current FSM state: 0 RUN, 1 STALL, 2 MEM_WAIT.
- o_hang  output  1  sticky flag: stall exceeded MAX_STALL.
- o_stall_cycles  output  CNT_W  saturating count of cycles with o_pc_en low.
- o_flush_count  output  CNT_W  saturating count of taken-branch flushes.

Behaviour:
- Reset:
  - While rst=1: state RUN, internal stall run counter 0, o_hang=0, both perf counters 0.
  - Outputs while rst=1: all enables 0, o_if_id_flush=1, o_id_ex_flush=1.
- Control outputs are combinational from the registered state and the current inputs. Evaluation priority: MEM_WAIT > stall > imem miss > branch flush.
- MEM_WAIT condition: i_dmem_ready=0 in any state.
  - All enables 0, no flushes.
  - Next state MEM_WAIT; return to RUN on the first cycle i_dmem_ready=1.
  - The stall run counter holds.
  - A branch or stall present during the wait is re-evaluated after exit, because decode is frozen.
- Hazard stall: i_stall=1 with i_dmem_ready=1.
  - o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1.
  - o_ex_mem_en=1, o_mem_wb_en=1.
  - Next state STALL; the stall run counter increments, saturating at 255.
  - i_branch_taken is ignored: the branch's operands are not yet valid.
- STALL state:
  - Same outputs while i_stall=1.
  - When i_stall=0, normal RUN outputs apply in that same cycle, next state RUN, and the stall run counter clears.
- Hang flag: o_hang sets on the edge where the stall run counter reaches MAX_STALL. It stays set until rst.
- Imem miss: RUN, i_imem_ready=0, no stall.
  - o_pc_en=0, o_if_id_en=1, o_if_id_flush=1, so a NOP enters decode.
  - Later stages advance.
- Taken branch: no stall, imem ready, i_branch_taken=1.
  - All enables 1, o_if_id_flush=1, kills the single wrong-path fetch.
  - o_flush_count increments.
  - Branch and imem miss together: flush once, counted once.
- Normal RUN: all enables 1, no flushes.
- Counters:
  - o_stall_cycles increments on every cycle o_pc_en=0 with rst=0.
  - Both counters saturate at all-ones and never wrap.
- A flush asserted together with its register enable means load NOP. A flush without the enable is never produced, except during rst.

Test Plan:
- Reset, then rst=1 held 3 cycles mid-stall → o_state=0, all enables 0, both flushes 1, counters 0, o_hang=0; on release all enables 1 with no flush.
- i_stall pulsed high 1 cycle → o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_ex_mem_en=1 for exactly 1 cycle; o_state 1 then 0; o_stall_cycles=1.
- i_stall high with i_branch_taken high 2 cycles, then stall drops with branch still high → no flush during stall; o_if_id_flush=1 on the third cycle; o_flush_count=1.
- i_dmem_ready low 4 cycles while i_stall=1 → all enables 0 for 4 cycles, o_state=2; afterward 1 stall cycle, then RUN; o_stall_cycles=5.
- i_stall held 10 cycles with MAX_STALL=8 → o_hang rises after the 8th stall cycle and stays 1 after stall ends, until rst.
- CNT_W=4, 20 consecutive taken branches → o_flush_count saturates at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl
// ----------------------------------------------------------------------------
// Central pipeline control stage, placed directly downstream of the
// forwarding unit. It turns the hazard stall request, the decode-stage
// branch decision and the instruction/data memory ready handshakes into
// per-stage register enables, NOP/bubble flush controls and a pair of
// saturating performance counters. It also raises a sticky hang flag when
// a hazard stall persists for too long.
//
// Parameters:
//   CNT_W      width of each saturating performance counter
//   MAX_STALL  consecutive hazard-stall cycles that set the hang flag (1..255)
//
// Ports:
//   clk             core clock, rising edge
//   rst             synchronous reset, active-high
//   i_stall         hazard stall request (load-use / branch dependency)
//   i_branch_taken  branch/jump resolved taken in decode this cycle
//   i_imem_ready    fetch data valid this cycle
//   i_dmem_ready    data memory ready; low means the MEM stage is busy
//   o_pc_en         PC update enable
//   o_if_id_en      IF/ID register enable
//   o_if_id_flush   load NOP into IF/ID
//   o_id_ex_en      ID/EX register enable
//   o_id_ex_flush   load bubble into ID/EX
//   o_ex_mem_en     EX/MEM register enable
//   o_mem_wb_en     MEM/WB register enable
//   o_state         current state: 0 RUN, 1 STALL, 2 MEM_WAIT
//   o_hang          sticky: hazard stall lasted MAX_STALL cycles
//   o_stall_cycles  saturating count of cycles with o_pc_en low
//   o_flush_count   saturating count of taken-branch flushes
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_stall,
    input  logic             i_branch_taken,
    input  logic             i_imem_ready,
    input  logic             i_dmem_ready,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_en,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_en,
    output logic [1:0]       o_state,
    output logic             o_hang,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      run_cnt;
    logic [7:0]      run_cnt_next;
    logic            count_flush;
    logic            hang;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Next-state and control decode. A busy data memory freezes the whole
    // pipe and outranks everything; a hazard stall freezes PC and IF/ID and
    // inserts a bubble into ID/EX while the older instructions drain. Only
    // when neither applies are the imem miss and taken-branch cases looked
    // at, so a branch seen during a stall or wait is simply re-evaluated
    // once decode is released.
    always_comb begin
        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_if_id_flush = 1'b0;
        o_id_ex_en    = 1'b0;
        o_id_ex_flush = 1'b0;
        o_ex_mem_en   = 1'b0;
        o_mem_wb_en   = 1'b0;
        state_next    = ST_RUN;
        run_cnt_next  = 8'd0;
        count_flush   = 1'b0;

        if (rst) begin
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
        end else if (!i_dmem_ready) begin
            state_next   = ST_MEM_WAIT;
            run_cnt_next = run_cnt;
        end else if (i_stall) begin
            o_id_ex_en    = 1'b1;
            o_id_ex_flush = 1'b1;
            o_ex_mem_en   = 1'b1;
            o_mem_wb_en   = 1'b1;
            state_next    = ST_STALL;
            run_cnt_next  = (run_cnt == 8'hFF) ? run_cnt : run_cnt + 8'd1;
        end else begin
            o_pc_en     = 1'b1;
            o_if_id_en  = 1'b1;
            o_id_ex_en  = 1'b1;
            o_ex_mem_en = 1'b1;
            o_mem_wb_en = 1'b1;
            // Fetch miss: hold the PC and feed a NOP into decode.
            if (!i_imem_ready) begin
                o_pc_en       = 1'b0;
                o_if_id_flush = 1'b1;
            end
            // Taken branch kills the single wrong-path fetch; when it
            // coincides with a miss the one flush covers both and is
            // counted once.
            if (i_branch_taken) begin
                o_if_id_flush = 1'b1;
                count_flush   = 1'b1;
            end
        end
    end

    // State register, stall run length, sticky hang flag and the two
    // saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            run_cnt   <= 8'd0;
            hang      <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= state_next;
            run_cnt <= run_cnt_next;
            if (run_cnt_next == 8'(MAX_STALL)) begin
                hang <= 1'b1;
            end
            if (!o_pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (count_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign o_state        = state;
    assign o_hang         = hang;
    assign o_stall_cycles = stall_cnt;
    assign o_flush_count  = flush_cnt;

endmodule
